// File: rtl/cs_feeder.sv
// cs_feeder: FIFO-buffered, gap-free sample feeder for the 9-tap sliding-window smoother
// Ports: clk, reset (sync, active-low); in_data/in_valid/in_ready upstream handshake;
//        start/frame_len begin a frame; X/x_valid sample stream to the smoother;
//        y_valid qualifies smoother Y; busy, done (pulse), underrun (sticky).
// Optional: define CS_REPLAY_EN to re-drive the last sample on FIFO underrun instead of zeros.
module cs_feeder #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int WIN   = 9,
    parameter int LW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          start,
    input  logic [LW-1:0] frame_len,
    output logic [DW-1:0] X,
    output logic          x_valid,
    output logic          y_valid,
    output logic          busy,
    output logic          done,
    output logic          underrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(WIN + 1);
    localparam logic [WW-1:0] WMAX  = WW'(WIN);
    localparam logic [WW-1:0] WLAST = WW'(WIN - 1);

    typedef enum logic [1:0] {IDLE, PREFILL, STREAM, DRAIN} state_t;
    state_t state, state_nx;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [LW-1:0] rem, need;
    logic [WW-1:0] win_cnt;
    logic push, pop, empty;

    assign empty    = count == '0;
    assign in_ready = reset && (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = state == STREAM && !empty;
    assign busy     = state != IDLE;
    // Short frames only need all their samples buffered before streaming.
    assign need     = (rem < LW'(WIN)) ? rem : LW'(WIN);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (start && frame_len != '0) ? PREFILL : IDLE;
            PREFILL: state_nx = (LW'(count) >= need) ? STREAM : PREFILL;
            STREAM:  state_nx = (pop && rem == LW'(1)) ? DRAIN : STREAM;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (!reset) state <= IDLE;
        else state <= state_nx;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= in_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rem      <= '0;
            win_cnt  <= '0;
            X        <= '0;
            x_valid  <= 1'b0;
            y_valid  <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(push);
            rd_ptr  <= rd_ptr + AW'(pop);
            count   <= count + CW'(push) - CW'(pop);
            done    <= state == DRAIN || (state == IDLE && start && frame_len == '0);
            // x_valid high at this edge means the smoother captures X now.
            y_valid <= x_valid && win_cnt >= WLAST;
            if (x_valid) win_cnt <= (win_cnt == WMAX) ? win_cnt : win_cnt + 1'b1;
            if (state == STREAM) begin
                if (!empty) begin
                    X       <= mem[rd_ptr];
                    x_valid <= 1'b1;
                    rem     <= rem - LW'(1);
                end else begin
`ifdef CS_REPLAY_EN
                    x_valid  <= 1'b1;
`else
                    X        <= '0;
                    x_valid  <= 1'b0;
                    win_cnt  <= '0;
`endif
                    underrun <= 1'b1;
                end
            end else begin
                X       <= '0;
                x_valid <= 1'b0;
            end
            if (state == IDLE && start) begin
                rem      <= frame_len;
                underrun <= 1'b0;
                win_cnt  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cs_feeder.sv
// tb_cs_feeder: directed self-checking bench for cs_feeder
module tb_cs_feeder;
    localparam int DW = 8;
    localparam int LW = 16;

    logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, start = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [LW-1:0] frame_len = '0;
    logic in_ready, x_valid, y_valid, busy, done, underrun;
    logic [DW-1:0] X;

    int checks = 0, errors = 0;
    int yv_cnt = 0, busy_cnt = 0, xz_bad = 0, done_cnt = 0, done_yv = 0;
    int b_yv, b_busy, b_xz, b_done, b_dyv, b_xs;
    logic [DW-1:0] xs[$];

    always #5 clk = ~clk;

    cs_feeder dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .start(start), .frame_len(frame_len), .X(X),
        .x_valid(x_valid), .y_valid(y_valid), .busy(busy), .done(done),
        .underrun(underrun)
    );

    always @(negedge clk)
        if (reset) begin
            if (x_valid) xs.push_back(X);
            if (y_valid) yv_cnt <= yv_cnt + 1;
            if (busy) busy_cnt <= busy_cnt + 1;
            if (busy && !x_valid && X != '0) xz_bad <= xz_bad + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (done && y_valid) done_yv <= done_yv + 1;
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] xs_at(input int i);
        if (b_xs + i < xs.size()) return 32'(xs[b_xs + i]);
        return 'x;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int base, input int n, input int step);
        for (int i = 0; i < n; i++) begin
            in_data  = DW'(base + i * step);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic go(input int len);
        start     = 1'b1;
        frame_len = LW'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic snap;
        b_yv = yv_cnt; b_busy = busy_cnt; b_xz = xz_bad;
        b_done = done_cnt; b_dyv = done_yv; b_xs = xs.size();
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!done && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", n < lim, 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (2) tick();
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_outputs", {X, x_valid, y_valid, busy, done, underrun}, 0);
        reset = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_busy", busy, 0);

        // full 16-sample frame from a full FIFO
        preload(1, 16, 1);
        check("full_in_ready", in_ready, 0);
        snap();
        go(16);
        wait_done(60);
        check("t1_xv", xs.size() - b_xs, 16);
        for (int i = 0; i < 16; i++) check("t1_x", xs_at(i), i + 1);
        check("t1_yv", yv_cnt - b_yv, 8);
        check("t1_done", done_cnt - b_done, 1);
        check("t1_done_yv", done_yv - b_dyv, 1);
        check("t1_busy", busy_cnt - b_busy, 18);
        check("t1_underrun", underrun, 0);
        check("t1_in_ready", in_ready, 1);

        // exact-window frame, with a start pulse while busy
        preload(200, 9, 0);
        snap();
        go(9);
        start = 1'b1;
        frame_len = 3;
        tick();
        start = 1'b0;
        wait_done(60);
        check("t2_xv", xs.size() - b_xs, 9);
        check("t2_x0", xs_at(0), 200);
        check("t2_x8", xs_at(8), 200);
        check("t2_yv", yv_cnt - b_yv, 1);
        check("t2_done", done_cnt - b_done, 1);
        check("t2_done_yv", done_yv - b_dyv, 1);
        check("t2_busy", busy_cnt - b_busy, 11);

        // zero-length frame
        snap();
        go(0);
        @(negedge clk);
        check("t3_done", done, 1);
        check("t3_busy", busy, 0);
        @(negedge clk);
        check("t3_done_off", done, 0);
        check("t3_xv", xs.size() - b_xs, 0);
        check("t3_busy_cnt", busy_cnt - b_busy, 0);

        // upstream stall: FIFO runs dry after sample 12 for three edges
        preload(1, 12, 1);
        snap();
        go(20);
        repeat (15) tick();
        preload(13, 8, 1);
        wait_done(60);
        check("t4_busy", busy_cnt - b_busy, 25);
        check("t4_xz", xz_bad - b_xz, 0);
        check("t4_underrun", underrun, 1);
        check("t4_done", done_cnt - b_done, 1);
        check("t4_x11", xs_at(11), 12);
`ifdef CS_REPLAY_EN
        check("t4_xv", xs.size() - b_xs, 23);
        check("t4_x14", xs_at(14), 12);
        check("t4_x15", xs_at(15), 13);
        check("t4_x22", xs_at(22), 20);
        check("t4_yv", yv_cnt - b_yv, 15);
        check("t4_done_yv", done_yv - b_dyv, 1);
`else
        check("t4_xv", xs.size() - b_xs, 20);
        check("t4_x12", xs_at(12), 13);
        check("t4_x19", xs_at(19), 20);
        check("t4_yv", yv_cnt - b_yv, 4);
        check("t4_done_yv", done_yv - b_dyv, 0);
`endif

        // reset in the middle of a stream
        preload(101, 16, 1);
        snap();
        go(16);
        check("t5_underrun_clr", underrun, 0);
        repeat (5) tick();
        reset = 1'b0;
        @(negedge clk);
        check("t5_rst_in_ready", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("t5_rst_outputs", {X, x_valid, y_valid, busy, done, underrun}, 0);
        reset = 1'b1;
        tick();
        check("t5_in_ready", in_ready, 1);
        check("t5_no_done", done_cnt - b_done, 0);
        preload(50, 9, 1);
        snap();
        go(9);
        wait_done(60);
        check("t5_xv", xs.size() - b_xs, 9);
        check("t5_x0", xs_at(0), 50);
        check("t5_x8", xs_at(8), 58);
        check("t5_yv", yv_cnt - b_yv, 1);
        check("t5_done", done_cnt - b_done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
